alignment_marker_inserter: RTL and testbench

Parametrised PCS transmit alignment-marker inserter for multi-lane 40G/100GBASE-R. It sits between the per-lane scrambler output and the PMA gearbox. Every GAP_N accepted blocks it stalls upstream for one cycle and emits one alignment-marker block on every lane. Each lane's BIP3/BIP7 field is computed over all blocks sent on that lane since the previous marker. All lanes share one gap counter, so markers appear on every lane in the same cycle.

---
 rtl/alignment_marker_inserter_if.sv | 26 ++
 rtl/alignment_marker_inserter.sv | 116 +++++++++++
 tb/tb_alignment_marker_inserter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alignment_marker_inserter_if.sv
// Block stream between the per-lane scrambler, the alignment-marker inserter and the PMA gearbox.
// The master drives the *_i signals and the slave (the inserter) drives the *_o signals.
interface alignment_marker_inserter_if #(
  parameter int unsigned LANE_N = 4,
  parameter int unsigned HEAD_W = 2,
  parameter int unsigned DATA_W = 64
);
  logic                       valid_i;
  logic                       ready_o;
  logic [LANE_N*HEAD_W-1:0]   head_i;
  logic [LANE_N*DATA_W-1:0]   data_i;
  logic                       valid_o;
  logic                       marker_v_o;
  logic [LANE_N*HEAD_W-1:0]   head_o;
  logic [LANE_N*DATA_W-1:0]   data_o;

  modport master (
    output valid_i, head_i, data_i,
    input  ready_o, valid_o, marker_v_o, head_o, data_o
  );

  modport slave (
    input  valid_i, head_i, data_i,
    output ready_o, valid_o, marker_v_o, head_o, data_o
  );
endinterface

// File: rtl/alignment_marker_inserter.sv
// Multi-lane 40G/100GBASE-R transmit alignment-marker inserter: one marker per lane every GAP_N blocks.
// Define ALIGN_MARKER_BIP_EN to build the per-lane BIP accumulators; otherwise BIP3=00, BIP7=FF.
module alignment_marker_inserter #(
  parameter int unsigned LANE_N = 4,
  parameter int unsigned HEAD_W = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned GAP_N  = 16383,
  parameter logic [LANE_N*48-1:0] MARKER_ENC = {48'hC2865D3D79A2, 48'h649A3A9B65C5,
                                                48'h193B0FE6C4F0, 48'hB8896F477690}
) (
  input  logic clk,
  input  logic nreset,
  alignment_marker_inserter_if.slave bus
);
  localparam int unsigned GAP_W = 20;

  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     valid_q, valid_d;
  logic                     marker_q, marker_d;
  logic [LANE_N*HEAD_W-1:0] head_q, head_d, mk_head;
  logic [LANE_N*DATA_W-1:0] data_q, data_d, mk_data;
  logic [LANE_N*8-1:0]      bip;
  logic                     marker_due;
  logic                     accept;

  assign marker_due  = (gap_q == GAP_W'(GAP_N));
  assign bus.ready_o = nreset & ~marker_due;
  assign accept      = bus.valid_i & bus.ready_o;

  // Marker bytes 0..7 = M0 M1 M2 BIP3 M4 M5 M6 BIP7, byte 0 in the LSBs.
  always_comb begin
    mk_head = '0;
    mk_data = '0;
    for (int unsigned l = 0; l < LANE_N; l++) begin
      mk_head[l*HEAD_W +: HEAD_W] = HEAD_W'(2'b01);
      mk_data[l*DATA_W +: DATA_W] = DATA_W'({~bip[l*8 +: 8], MARKER_ENC[l*48+24 +: 24],
                                              bip[l*8 +: 8], MARKER_ENC[l*48 +: 24]});
    end
  end

  always_comb begin
    gap_d    = gap_q;
    valid_d  = 1'b0;
    marker_d = 1'b0;
    head_d   = head_q;
    data_d   = data_q;
    if (marker_due) begin
      gap_d    = '0;
      valid_d  = 1'b1;
      marker_d = 1'b1;
      head_d   = mk_head;
      data_d   = mk_data;
    end else if (accept) begin
      gap_d   = gap_q + GAP_W'(1);
      valid_d = 1'b1;
      head_d  = bus.head_i;
      data_d  = bus.data_i;
    end
  end

  // Loading the counter with GAP_N on reset makes the first output a marker.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      gap_q    <= GAP_W'(GAP_N);
      valid_q  <= 1'b0;
      marker_q <= 1'b0;
      head_q   <= '0;
      data_q   <= '0;
    end else begin
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      marker_q <= marker_d;
      head_q   <= head_d;
      data_q   <= data_d;
    end
  end

`ifdef ALIGN_MARKER_BIP_EN
  logic [LANE_N*8-1:0] acc_q, acc_d;

  // Bit j = parity of data bits j, j+8, ..; sync header bits fold into bits 3 and 4.
  function automatic logic [7:0] bip_f(input logic [HEAD_W-1:0] h, input logic [DATA_W-1:0] d);
    logic [7:0] p;
    p = '0;
    for (int unsigned i = 0; i < DATA_W; i++) p[i[2:0]] = p[i[2:0]] ^ d[i];
    p[3] = p[3] ^ h[0];
    p[4] = p[4] ^ h[1];
    return p;
  endfunction

  always_comb begin
    acc_d = acc_q;
    for (int unsigned l = 0; l < LANE_N; l++) begin
      if (marker_due)
        acc_d[l*8 +: 8] = bip_f(mk_head[l*HEAD_W +: HEAD_W], mk_data[l*DATA_W +: DATA_W]);
      else if (accept)
        acc_d[l*8 +: 8] = acc_q[l*8 +: 8] ^
                          bip_f(bus.head_i[l*HEAD_W +: HEAD_W], bus.data_i[l*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign bip = acc_q;
`else
  assign bip = '0;
`endif

  assign bus.valid_o    = valid_q;
  assign bus.marker_v_o = marker_q;
  assign bus.head_o     = head_q;
  assign bus.data_o     = data_q;
endmodule

// File: tb/tb_alignment_marker_inserter.sv
// Randomized scoreboard bench for alignment_marker_inserter with a block-level reference model.
module tb_alignment_marker_inserter;
  localparam int unsigned LN = 4;
  localparam int unsigned HW = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned G  = 4;

  // M0 M1 M2 M4 M5 M6 for 40GBASE-R lanes 0..3
  localparam logic [7:0] AM [4][6] = '{
    '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
    '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
    '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
    '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}};

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  alignment_marker_inserter_if #(.LANE_N(LN), .HEAD_W(HW), .DATA_W(DW)) bus();

  alignment_marker_inserter #(.LANE_N(LN), .HEAD_W(HW), .DATA_W(DW), .GAP_N(G)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  typedef struct packed {
    logic             mk;
    logic [LN*HW-1:0] h;
    logic [LN*DW-1:0] d;
  } item_t;

  item_t            exp_q[$];
  int               errors = 0;
  int               checks = 0;
  int               cnt;
  logic [7:0]       acc_m [LN];
  bit               pending = 0;
  logic [LN*HW-1:0] cur_h = '0;
  logic [LN*DW-1:0] cur_d = '0;

  function automatic logic [7:0] f_model(input logic [1:0] h, input logic [63:0] d);
    logic [65:0] blk;
    logic [7:0]  r;
    blk = {d, h};
    r = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++) r[j] = r[j] ^ blk[2 + j + 8*k];
    r[3] = r[3] ^ blk[0];
    r[4] = r[4] ^ blk[1];
    return r;
  endfunction

  task automatic push_marker();
    item_t      it;
    logic [7:0] b [8];
    logic [7:0] bip;
    it.mk = 1'b1;
    it.h  = '0;
    it.d  = '0;
    for (int l = 0; l < LN; l++) begin
`ifdef ALIGN_MARKER_BIP_EN
      bip = acc_m[l];
`else
      bip = 8'h00;
`endif
      b[0] = AM[l][0]; b[1] = AM[l][1]; b[2] = AM[l][2]; b[3] = bip;
      b[4] = AM[l][3]; b[5] = AM[l][4]; b[6] = AM[l][5]; b[7] = ~bip;
      for (int i = 0; i < 8; i++) it.d[l*64 + 8*i +: 8] = b[i];
      it.h[l*2 +: 2] = 2'b01;
      acc_m[l] = f_model(2'b01, it.d[l*64 +: 64]);
    end
    exp_q.push_back(it);
  endtask

  task automatic push_data();
    item_t it;
    it.mk = 1'b0;
    it.h  = cur_h;
    it.d  = cur_d;
    for (int l = 0; l < LN; l++)
      acc_m[l] = acc_m[l] ^ f_model(cur_h[l*2 +: 2], cur_d[l*64 +: 64]);
    exp_q.push_back(it);
  endtask

  // One cycle of upstream traffic; an unaccepted block is held until taken.
  task automatic step(input bit want_valid, input bit ones);
    bit v;
    bit due;
    if (pending) begin
      v = 1'b1;
    end else begin
      v = want_valid;
      if (ones) begin
        cur_h = '1;
        cur_d = '1;
      end else begin
        cur_h = 8'($urandom());
        for (int i = 0; i < int'(LN*DW/32); i++) cur_d[i*32 +: 32] = $urandom();
      end
    end
    bus.valid_i = v;
    bus.head_i  = cur_h;
    bus.data_i  = cur_d;
    due = (cnt == int'(G));
    checks++;
    if (bus.ready_o !== !due) begin
      errors++;
      $display("FAIL ready_o: got %b expected %b (model count %0d)", bus.ready_o, !due, cnt);
    end
    if (due) begin
      push_marker();
      cnt = 0;
      pending = v;
    end else if (v) begin
      push_data();
      cnt++;
      pending = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    nreset = 1'b0;
    bus.valid_i = 1'b0;
    pending = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.marker_v_o !== 1'b0 || bus.head_o !== '0 ||
          bus.data_o !== '0 || bus.ready_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b marker=%b ready=%b head=%h data=%h expected all zero",
                 bus.valid_o, bus.marker_v_o, bus.ready_o, bus.head_o, bus.data_o);
      end
    end
    nreset = 1'b1;
    cnt = int'(G);
    for (int l = 0; l < LN; l++) acc_m[l] = 8'h00;
  endtask

  // Monitor: every presented output block is compared against the next expected block.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got marker=%b head=%h with no block expected",
                   bus.marker_v_o, bus.head_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.marker_v_o !== e.mk || bus.head_o !== e.h || bus.data_o !== e.d) begin
            errors++;
            $display("FAIL out_block: got mk=%b h=%h d=%h expected mk=%b h=%h d=%h",
                     bus.marker_v_o, bus.head_o, bus.data_o, e.mk, e.h, e.d);
          end
        end
      end else if (bus.marker_v_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL marker_without_valid: got marker_v_o=%b valid_o=%b expected marker_v_o=0",
                 bus.marker_v_o, bus.valid_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.head_i  = '0;
    bus.data_i  = '0;
    do_reset(3);

    step(1'b1, 1'b0);
    checks++;
    if (bus.marker_v_o !== 1'b1 || bus.head_o[1:0] !== 2'b01 ||
        bus.data_o[63:0] !== 64'hFFB8896F00477690) begin
      errors++;
      $display("FAIL first_marker_lane0: got mk=%b h=%b d=%h expected mk=1 h=01 d=ffb8896f00477690",
               bus.marker_v_o, bus.head_o[1:0], bus.data_o[63:0]);
    end

    for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) step($urandom_range(0, 3) != 0, 1'b0);

    for (int i = 0; i < 20 && cnt != 2; i++) step(1'b1, 1'b0);
    do_reset(2);
    for (int i = 0; i < 30; i++) step($urandom_range(0, 2) != 0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d blocks never output, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
